// File: rtl/m_ifetch_queue_pkg.sv
// Shared types and constants for the instruction-fetch queue.
package m_ifetch_queue_pkg;

   // Opcode used on the head instruction output whenever the queue is empty.
   localparam logic [31:0] NOP = {21'h0, 11'h20};

   // Width of one queue entry: instruction word plus its PC (pc4 is derived at the head).
   localparam int IFQ_ENTRY = 64;

   typedef struct packed {
      logic [31:0] ir;
      logic [31:0] pc;
   } ifq_entry_t;

endpackage

// File: rtl/m_ifq_fifo.sv
// Small circular register-array FIFO holding fetched (ir, pc) entries.
// Purely a storage element: it knows nothing about redirects or killed responses.
module m_ifq_fifo
   import m_ifetch_queue_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   push,
   input  logic                   pop,
   input  logic                   clear,
   input  ifq_entry_t             din,
   output ifq_entry_t             dout,
   output logic [$clog2(DEPTH):0] count
);

   localparam int PW = $clog2(DEPTH);

   ifq_entry_t    mem_q [DEPTH];
   ifq_entry_t    mem_d [DEPTH];
   logic [PW-1:0] head_q, head_d;
   logic [PW-1:0] tail_q, tail_d;
   logic [PW:0]   count_q, count_d;

   // Next-state for storage, pointers and occupancy; clear overrides push/pop.
   always_comb begin
      mem_d   = mem_q;
      head_d  = head_q;
      tail_d  = tail_q;
      count_d = count_q;
      if (clear) begin
         head_d  = '0;
         tail_d  = '0;
         count_d = '0;
      end else begin
         if (push) begin
            mem_d[tail_q] = din;
            tail_d        = tail_q + 1'b1;
         end else begin
            tail_d = tail_q;
         end
         if (pop) begin
            head_d = head_q + 1'b1;
         end else begin
            head_d = head_q;
         end
         if (push && !pop) begin
            count_d = count_q + 1'b1;
         end else if (!push && pop) begin
            count_d = count_q - 1'b1;
         end else begin
            count_d = count_q;
         end
      end
   end

   // State registers with asynchronous reset to an empty queue.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= '0;
         end
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
      end else begin
         mem_q   <= mem_d;
         head_q  <= head_d;
         tail_q  <= tail_d;
         count_q <= count_d;
      end
   end

   assign dout  = mem_q[head_q];
   assign count = count_q;

endmodule

// File: rtl/m_ifetch_queue.sv
// Decoupled instruction-fetch front end: fetch PC, synchronous imem request,
// one-deep in-flight tracking and a small instruction queue popped by ID.
module m_ifetch_queue
   import m_ifetch_queue_pkg::*;
#(
   parameter int          DEPTH    = 4,
   parameter int          AW       = 12,
   parameter logic [31:0] RESET_PC = 32'h0
) (
   input  logic                   w_clk,
   input  logic                   w_rst,
   input  logic                   w_redirect,
   input  logic [31:0]            w_tpc,
   input  logic                   w_halt,
   output logic                   r_ireq,
   output logic [AW-1:0]          r_iaddr,
   input  logic [31:0]            w_idata,
   output logic                   w_valid,
   input  logic                   w_ready,
   output logic [31:0]            w_ir,
   output logic [31:0]            w_pc,
   output logic [31:0]            w_pc4,
   output logic [$clog2(DEPTH):0] r_count
);

   localparam int CW = $clog2(DEPTH) + 1;

   logic [31:0]   fetch_pc_q, fetch_pc_d;
   logic [31:0]   tag_q, tag_d;
   logic          inflight_q, inflight_d;
   logic [CW:0]   credit;
   logic          issue;
   logic          push;
   logic          pop;
   ifq_entry_t    fifo_din;
   ifq_entry_t    fifo_dout;
   logic [CW-1:0] fifo_count;

   // Issue/credit decision, kill gating and fetch PC / in-flight tag update.
   // A redirect blocks issue, so at most the one word already in flight is killed.
   always_comb begin
      credit     = {1'b0, fifo_count} + {{CW{1'b0}}, inflight_q};
      issue      = !w_rst && !w_halt && !w_redirect && (int'(credit) < DEPTH);
      push       = inflight_q && !w_redirect;
      pop        = w_valid && w_ready && !w_redirect;
      fetch_pc_d = fetch_pc_q;
      tag_d      = tag_q;
      inflight_d = issue;
      if (w_redirect) begin
         fetch_pc_d = w_tpc;
      end else if (issue) begin
         fetch_pc_d = fetch_pc_q + 32'd4;
         tag_d      = fetch_pc_q;
      end else begin
         fetch_pc_d = fetch_pc_q;
      end
   end

   // Fetch PC, in-flight flag and its PC tag.
   always_ff @(posedge w_clk or posedge w_rst) begin
      if (w_rst) begin
         fetch_pc_q <= RESET_PC;
         tag_q      <= 32'h0;
         inflight_q <= 1'b0;
      end else begin
         fetch_pc_q <= fetch_pc_d;
         tag_q      <= tag_d;
         inflight_q <= inflight_d;
      end
   end

   assign fifo_din = '{ir: w_idata, pc: tag_q};

   m_ifq_fifo #(
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk   (w_clk),
      .rst   (w_rst),
      .push  (push),
      .pop   (pop),
      .clear (w_redirect),
      .din   (fifo_din),
      .dout  (fifo_dout),
      .count (fifo_count)
   );

   // Request outputs and head muxing; an empty queue presents a NOP at PC 0.
   always_comb begin
      r_ireq  = issue;
      r_iaddr = w_rst ? '0 : fetch_pc_q[AW+1:2];
      r_count = fifo_count;
      w_valid = (fifo_count != '0);
      if (w_valid) begin
         w_ir = fifo_dout.ir;
         w_pc = fifo_dout.pc;
      end else begin
         w_ir = NOP;
         w_pc = 32'h0;
      end
      w_pc4 = w_pc + 32'd4;
   end

endmodule

// File: tb/tb_m_ifetch_queue.sv
// Self-checking bench for m_ifetch_queue: directed scenarios plus random
// traffic, compared each cycle against a queue-based reference model.
module tb_m_ifetch_queue;

   localparam int DEPTH = 4;
   localparam int AW    = 12;

   typedef struct {
      logic [31:0] pc;
      logic [31:0] ir;
   } ent_t;

   logic          w_clk;
   logic          w_rst;
   logic          w_redirect;
   logic [31:0]   w_tpc;
   logic          w_halt;
   logic          r_ireq;
   logic [AW-1:0] r_iaddr;
   logic [31:0]   w_idata;
   logic          w_valid;
   logic          w_ready;
   logic [31:0]   w_ir;
   logic [31:0]   w_pc;
   logic [31:0]   w_pc4;
   logic [2:0]    r_count;

   int n_total;
   int n_bad;

   logic [31:0] imem [4096];

   // reference model state
   ent_t        mq[$];
   bit          m_infl;
   logic [31:0] m_tag;
   logic [31:0] m_pc;

   m_ifetch_queue #(
      .DEPTH    (DEPTH),
      .AW       (AW),
      .RESET_PC (32'h0)
   ) dut (
      .w_clk      (w_clk),
      .w_rst      (w_rst),
      .w_redirect (w_redirect),
      .w_tpc      (w_tpc),
      .w_halt     (w_halt),
      .r_ireq     (r_ireq),
      .r_iaddr    (r_iaddr),
      .w_idata    (w_idata),
      .w_valid    (w_valid),
      .w_ready    (w_ready),
      .w_ir       (w_ir),
      .w_pc       (w_pc),
      .w_pc4      (w_pc4),
      .r_count    (r_count)
   );

   // free-running clock, posedges at 5, 15, 25, ...
   initial begin
      w_clk = 1'b0;
      forever #5 w_clk = ~w_clk;
   end

   task automatic chk_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   // Asynchronous reset pulse between edges; outputs are checked while reset is high.
   task automatic do_reset();
      #1;
      w_halt     = 1'b1;
      w_redirect = 1'b0;
      w_ready    = 1'b0;
      w_rst      = 1'b1;
      #1;
      chk_eq("rst_ireq",  {31'd0, r_ireq}, 32'd0);
      chk_eq("rst_iaddr", {20'd0, r_iaddr}, 32'd0);
      chk_eq("rst_valid", {31'd0, w_valid}, 32'd0);
      chk_eq("rst_ir",    w_ir, 32'h20);
      chk_eq("rst_pc",    w_pc, 32'h0);
      chk_eq("rst_pc4",   w_pc4, 32'h4);
      chk_eq("rst_count", {29'd0, r_count}, 32'd0);
      w_rst = 1'b0;
      mq.delete();
      m_infl = 1'b0;
      m_tag  = 32'h0;
      m_pc   = 32'h0;
      @(posedge w_clk);
      #1;
      w_idata = $urandom;
   endtask

   // One clock cycle: apply inputs, compare outputs at the negedge, advance the model.
   task automatic step(input bit rd, input logic [31:0] tpc, input bit hl, input bit rdy);
      bit          e_req;
      bit          e_valid;
      logic [31:0] e_ir;
      logic [31:0] e_pc;
      bit          req_s;
      logic [11:0] addr_s;
      logic [2:0]  cnt_s;
      ent_t        e;
      w_redirect = rd;
      w_tpc      = tpc;
      w_halt     = hl;
      w_ready    = rdy;
      #4;
      e_valid = (mq.size() != 0);
      e_req   = !hl && !rd && ((mq.size() + int'(m_infl)) < DEPTH);
      e_ir    = e_valid ? mq[0].ir : 32'h20;
      e_pc    = e_valid ? mq[0].pc : 32'h0;
      chk_eq("ireq", {31'd0, r_ireq}, {31'd0, e_req});
      if (e_req) chk_eq("iaddr", {20'd0, r_iaddr}, {20'd0, m_pc[13:2]});
      chk_eq("valid", {31'd0, w_valid}, {31'd0, e_valid});
      chk_eq("ir",    w_ir, e_ir);
      chk_eq("pc",    w_pc, e_pc);
      chk_eq("pc4",   w_pc4, e_pc + 32'd4);
      chk_eq("count", {29'd0, r_count}, 32'(mq.size()));
      req_s  = r_ireq;
      addr_s = r_iaddr;
      cnt_s  = r_count;
      @(posedge w_clk);
      if (rd) begin
         mq.delete();
         m_pc   = tpc;
         m_infl = 1'b0;
      end else begin
         if (m_infl) chk_eq("no_ovf", {31'd0, (int'(cnt_s) < DEPTH)}, 32'd1);
         if (e_valid && rdy) void'(mq.pop_front());
         if (m_infl) begin
            e.pc = m_tag;
            e.ir = imem[m_tag[13:2]];
            mq.push_back(e);
         end
         m_infl = e_req;
         if (e_req) begin
            m_tag = m_pc;
            m_pc  = m_pc + 32'd4;
         end
      end
      #1;
      w_idata = req_s ? imem[addr_s] : $urandom;
   endtask

   initial begin
      n_total    = 0;
      n_bad      = 0;
      w_rst      = 1'b1;
      w_redirect = 1'b0;
      w_tpc      = 32'h0;
      w_halt     = 1'b1;
      w_ready    = 1'b0;
      w_idata    = 32'h0;
      m_infl     = 1'b0;
      m_tag      = 32'h0;
      m_pc       = 32'h0;
      for (int i = 0; i < 4096; i++) imem[i] = 32'(i + 100);
      #6;

      // 1: streaming with ready high
      do_reset();
      for (int i = 0; i < 10; i++) step(1'b0, 32'h0, 1'b0, 1'b1);

      // 2: back-pressure saturates the queue, then drains in order
      do_reset();
      for (int i = 0; i < 8; i++) step(1'b0, 32'h0, 1'b0, 1'b0);
      chk_eq("sat_count", {29'd0, r_count}, 32'd4);
      for (int i = 0; i < 8; i++) step(1'b0, 32'h0, 1'b0, 1'b1);

      // 3: redirect with 3 queued and 1 in flight
      do_reset();
      for (int i = 0; i < 4; i++) step(1'b0, 32'h0, 1'b0, 1'b0);
      step(1'b1, 32'h40, 1'b0, 1'b0);
      for (int i = 0; i < 6; i++) step(1'b0, 32'h0, 1'b0, 1'b1);

      // 4: halt with 2 queued and 1 in flight, drain, then resume
      do_reset();
      for (int i = 0; i < 3; i++) step(1'b0, 32'h0, 1'b0, 1'b0);
      for (int i = 0; i < 6; i++) step(1'b0, 32'h0, 1'b1, 1'b1);
      step(1'b1, 32'h80, 1'b1, 1'b1);
      for (int i = 0; i < 2; i++) step(1'b0, 32'h0, 1'b1, 1'b1);
      for (int i = 0; i < 5; i++) step(1'b0, 32'h0, 1'b0, 1'b1);

      // 5: asynchronous reset mid-stream
      for (int i = 0; i < 3; i++) step(1'b0, 32'h0, 1'b0, 1'b1);
      do_reset();
      for (int i = 0; i < 5; i++) step(1'b0, 32'h0, 1'b0, 1'b1);

      // 6: PC wrap, plus push and pop together at DEPTH-1
      step(1'b1, 32'hFFFF_FFFC, 1'b0, 1'b0);
      for (int i = 0; i < 4; i++) step(1'b0, 32'h0, 1'b0, 1'b0);
      chk_eq("wrap_head", w_pc, 32'hFFFF_FFFC);
      for (int i = 0; i < 6; i++) step(1'b0, 32'h0, 1'b0, 1'b1);

      // random traffic with random memory contents
      do_reset();
      for (int i = 0; i < 4096; i++) imem[i] = $urandom;
      for (int i = 0; i < 400; i++) begin
         step(($urandom_range(0, 9) == 0), ($urandom & 32'hFFFF_FFFC),
              ($urandom_range(0, 3) == 0), ($urandom_range(0, 2) != 0));
      end

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
